seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, handshaked successor to the core's combinational ALU. Adds registered outputs, XOR/SLT/SLTU, shifts, and iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU). Sits between decode/operand-fetch and writeback. Uses valid/ready on both sides, so multi-cycle ops stall the pipeline without external counters.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept request this cycle
op  in  4  operation code (see Behaviour)
input_a  in  WIDTH  operand A
input_b  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flags  out  4  registered {N,Z,C,V}
busy  out  1  iterative op in progress

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, flags=0, busy=0, internal counters/accumulators cleared. Any op in flight is discarded.
- After reset release: in_ready=1.
- op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLT (signed), 0110 SLTU
  - 0111 SLL, 1000 SRL, 1001 SRA
  - 1010 MUL (low WIDTH bits), 1011 MULHU (high WIDTH bits, unsigned)
  - 1100 DIVU, 1101 REMU
  - others: result=0, flags=0100
- Shifts use input_b[SHW-1:0]; upper bits of B are ignored.
- States: IDLE, CALC, DONE.
- Accept (in_valid && in_ready at the edge) captures op, A and B. Later input changes are ignored.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back single-cycle ops, throughput 1/cycle.
- Single-cycle ops (0000-1001, undefined): accept -> DONE. out_valid=1 on the next edge (latency 1).
- MUL/MULHU: accept -> CALC.
  - Radix-2 shift-add over 2*WIDTH-bit product, exactly WIDTH iterations.
  - Then DONE: out_valid asserted WIDTH+1 edges after accept.
- DIVU/REMU: accept -> CALC.
  - Restoring divide, exactly WIDTH iterations.
  - Same WIDTH+1 latency.
- Divide by zero (B==0 at accept): no CALC. DONE after 1 edge.
  - DIVU result = all ones.
  - REMU result = A.
- busy=1 only in CALC. in_ready=0 in CALC.
- DONE: result/flags/out_valid held stable while out_valid && !out_ready.
  - out_ready=1 with no new accept -> IDLE, out_valid=0.
  - out_ready=1 with simultaneous accept -> next op starts. out_valid then follows the new op's latency (drops for iterative ops, stays high for single-cycle ops with new data).
- Flags:
  - N = result[WIDTH-1]
  - Z = (result==0)
  - C = bit WIDTH of the {0,A}+{0,B} (ADD) or {0,A}-{0,B} (SUB) extended result; for SUB this is the borrow. C=0 for all other ops.
  - V = signed overflow for ADD/SUB only. ADD: A,B same sign, result sign differs. SUB: A,B differ in sign, result sign differs from A. V=0 otherwise.
- SLT = sub_result[WIDTH-1] ^ V_sub. SLTU = borrow of A-B. Both zero-extended to WIDTH.
- All arithmetic is modulo 2^WIDTH except where an extended bit is stated.

Test Plan:
1. ADD A=0xFFFFFFFF, B=1, out_ready=1 -> one edge after accept: out_valid=1, result=0, flags=0110. SUB A=0x80000000, B=1 -> result=0x7FFFFFFF, flags=0001.
2. MUL A=B=0x00010000 -> result=0, flags=0100, out_valid exactly 33 edges after accept, busy=1 and in_ready=0 for 32 cycles. MULHU same operands -> result=1.
3. DIVU 100/7 -> 14. REMU 100/7 -> 2, latency 33. DIVU 5/0 -> 0xFFFFFFFF after 1 edge. REMU 5/0 -> 5 after 1 edge.
4. SRA 0x80000000 by B=0x23 (shamt 3) -> 0xF0000000. SLT A=0xFFFFFFFF, B=1 -> 1. SLTU same operands -> 0.
5. Backpressure: single-cycle ADD, hold out_ready=0 for 5 cycles -> result/flags/out_valid stable, in_ready=0. Then stream 4 ADDs with out_ready=1 -> one result per cycle, in order.
6. Reset: assert rst_n=0 at cycle 10 of a MUL -> outputs clear immediately (no clock needed). After release in_ready=1, and ADD 2+3 -> 5 with correct latency.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered outputs and iterative unsigned multiply/divide
module seq_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] op_r;
    logic [WIDTH-1:0] b_r, sc_res, fin_res;
    logic [2*WIDTH-1:0] acc, acc_nx;
    logic [SHW-1:0] cnt;
    logic [WIDTH:0] sum, diff, mul_sum, shifted, trial;
    logic [3:0] sc_flags;
    logic accept, iter_op, last, v_add, v_sub;

    assign accept  = in_valid && in_ready;
    assign iter_op = (op[3:1] == 3'b101) || ((op[3:1] == 3'b110) && (input_b != '0));
    assign last    = cnt == SHW'(WIDTH - 1);
    assign sum     = {1'b0, input_a} + {1'b0, input_b};
    assign diff    = {1'b0, input_a} - {1'b0, input_b};
    assign v_add   = (input_a[WIDTH-1] == input_b[WIDTH-1]) && (sum[WIDTH-1] != input_a[WIDTH-1]);
    assign v_sub   = (input_a[WIDTH-1] != input_b[WIDTH-1]) && (diff[WIDTH-1] != input_a[WIDTH-1]);

    // single-cycle result; DIVU/REMU entries only matter for the divide-by-zero shortcut
    always_comb begin
        sc_res = '0;
        case (op)
            4'd0:    sc_res = sum[WIDTH-1:0];
            4'd1:    sc_res = diff[WIDTH-1:0];
            4'd2:    sc_res = input_a & input_b;
            4'd3:    sc_res = input_a | input_b;
            4'd4:    sc_res = input_a ^ input_b;
            4'd5:    sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ v_sub};
            4'd6:    sc_res = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            4'd7:    sc_res = input_a << input_b[SHW-1:0];
            4'd8:    sc_res = input_a >> input_b[SHW-1:0];
            4'd9:    sc_res = $signed(input_a) >>> input_b[SHW-1:0];
            4'd12:   sc_res = '1;
            4'd13:   sc_res = input_a;
            default: sc_res = '0;
        endcase
        sc_flags = {sc_res[WIDTH-1], sc_res == '0,
                    op == 4'd0 ? sum[WIDTH] : op == 4'd1 ? diff[WIDTH] : 1'b0,
                    op == 4'd0 ? v_add : op == 4'd1 ? v_sub : 1'b0};
    end

    // one shift-add (MUL/MULHU) or restoring-divide (DIVU/REMU) step on {hi, lo}
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_r} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, b_r};
        acc_nx  = op_r[3:1] == 3'b101 ? {mul_sum, acc[WIDTH-1:1]} :
                  trial[WIDTH] ? {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                 {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        fin_res = op_r[0] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = state == DONE;
        busy      = state == CALC;
        state_nx  = state;
        if (accept) state_nx = iter_op ? CALC : DONE;
        else if (state == CALC) state_nx = last ? DONE : CALC;
        else if (state == DONE && out_ready) state_nx = IDLE;
    end

    // operand capture, iteration datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= '0;
            b_r    <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            flags  <= '0;
        end else if (accept) begin
            op_r <= op;
            b_r  <= input_b;
            acc  <= {{WIDTH{1'b0}}, input_a};
            cnt  <= '0;
            if (!iter_op) begin
                result <= sc_res;
                flags  <= sc_flags;
            end
        end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + SHW'(1);
            if (last) begin
                result <= fin_res;
                flags  <= {fin_res[WIDTH-1], fin_res == '0, 2'b00};
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: randomized and directed checking of seq_alu against a behavioural model
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, in_ready, out_valid, busy;
    logic [3:0] op, flags;
    logic [31:0] input_a, input_b, result;
    int n_checks = 0, n_pass = 0;
    bit cmp_en = 0;
    bit m_valid;
    int m_wait;
    logic [31:0] m_res, p_res;
    logic [3:0] m_flags, p_flags;

    seq_alu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .input_a(input_a), .input_b(input_b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [35:0] calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] w;
        logic [31:0] r;
        logic c, v;
        longint s, lim;
        lim = 64'sh80000000;
        r = 0; c = 0; v = 0;
        case (o)
            4'd0: begin
                w = {32'b0, a} + {32'b0, b}; r = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b)); v = s >= lim || s < -lim;
            end
            4'd1: begin
                r = a - b; c = a < b;
                s = longint'($signed(a)) - longint'($signed(b)); v = s >= lim || s < -lim;
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: r = (a < b) ? 32'd1 : 32'd0;
            4'd7: r = a << b[4:0];
            4'd8: r = a >> b[4:0];
            4'd9: r = $signed(a) >>> b[4:0];
            4'd10: begin w = {32'b0, a} * {32'b0, b}; r = w[31:0]; end
            4'd11: begin w = {32'b0, a} * {32'b0, b}; r = w[63:32]; end
            4'd12: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: r = (b == 0) ? a : a % b;
            default: r = 0;
        endcase
        return {r[31], r == 0, c, v, r};
    endfunction

    // behavioural model: cycles left until the pending result appears, and the shown result
    always @(posedge clk or negedge rst_n) begin
        logic [35:0] q;
        bit rdy;
        if (!rst_n) begin
            m_valid = 0; m_wait = 0; m_res = 0; m_flags = 0;
        end else begin
            rdy = (m_wait == 0 && !m_valid) || (m_valid && out_ready);
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin m_valid = 1; m_res = p_res; m_flags = p_flags; end
            end else if (m_valid && out_ready) m_valid = 0;
            if (in_valid && rdy) begin
                q = calc(op, input_a, input_b);
                if (op == 4'd10 || op == 4'd11 || ((op == 4'd12 || op == 4'd13) && input_b != 0)) begin
                    m_valid = 0; m_wait = 32; p_res = q[31:0]; p_flags = q[35:32];
                end else begin
                    m_valid = 1; m_res = q[31:0]; m_flags = q[35:32];
                end
            end
        end
    end

    // compare DUT against the model every cycle
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_out_valid", out_valid, m_valid);
            chk("cmp_in_ready", in_ready, (m_wait == 0 && !m_valid) || (m_valid && out_ready));
            chk("cmp_busy", busy, m_wait > 0);
            if (m_valid) begin
                chk("cmp_result", result, m_res);
                chk("cmp_flags", flags, m_flags);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        bit t, done;
        @(posedge clk); #2;
        op = o; input_a = a; input_b = b; in_valid = 1;
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk); t = in_ready;
            @(posedge clk); #2;
            if (t) begin in_valid = 0; done = 1; end
        end
        chk("issue_accepted", done, 1);
        in_valid = 0;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [3:0] ef, input int lat);
        logic [35:0] q;
        int n, nb;
        q = calc(o, a, b);
        chk("model_result", q[31:0], er);
        chk("model_flags", q[35:32], ef);
        out_ready = 1;
        issue(o, a, b);
        n = 0; nb = 0;
        while (n < 100) begin
            @(negedge clk); n++;
            if (out_valid) break;
            if (busy) nb++;
        end
        chk("latency", n, lat);
        chk("busy_cycles", nb, lat - 1);
        chk("result", result, er);
        chk("flags", flags, ef);
    endtask

    function automatic logic [31:0] rnd();
        logic [31:0] sp [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0: return 0;
            1: return $urandom_range(0, 15);
            2: return sp[$urandom_range(0, 2)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc_cnt;
        bit t;
        rst_n = 1; in_valid = 0; out_ready = 1; op = 0; input_a = 0; input_b = 0;
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", flags, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 1);
        cmp_en = 1;
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0110, 1);
        run_op(4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0001, 1);
        run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0, 4'b0100, 33);
        run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 32'd1, 4'b0000, 33);
        run_op(4'd12, 32'd100, 32'd7, 32'd14, 4'b0000, 33);
        run_op(4'd13, 32'd100, 32'd7, 32'd2, 4'b0000, 33);
        run_op(4'd12, 32'd5, 32'd0, 32'hFFFF_FFFF, 4'b1000, 1);
        run_op(4'd13, 32'd5, 32'd0, 32'd5, 4'b0000, 1);
        run_op(4'd9, 32'h8000_0000, 32'h23, 32'hF000_0000, 4'b1000, 1);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0000, 1);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0100, 1);
        run_op(4'd15, 32'h1234_5678, 32'd9, 32'd0, 4'b0100, 1);
        issue(4'd0, 32'd7, 32'd8);
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, 15);
        end
        op = 0; input_a = 0; input_b = 0; in_valid = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (i < 3) begin input_a = (i + 1) * 10; input_b = i + 1; end
            else in_valid = 0;
            @(negedge clk);
            chk("stream_valid", out_valid, 1);
            chk("stream_result", result, i * 11);
        end
        @(posedge clk); #2;
        acc_cnt = 0;
        for (int c = 0; c < 12000 && acc_cnt < 150; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (!in_valid && $urandom_range(0, 2) != 0) begin
                op = 4'($urandom_range(0, 15)); input_a = rnd(); input_b = rnd(); in_valid = 1;
            end
            @(negedge clk); t = in_valid && in_ready;
            @(posedge clk); #2;
            if (t) begin in_valid = 0; acc_cnt++; end
        end
        in_valid = 0; out_ready = 1;
        repeat (40) @(posedge clk);
        issue(4'd10, 32'h0012_3456, 32'h0000_0777);
        repeat (9) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_result", result, 0);
        chk("async_flags", flags, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        run_op(4'd0, 32'd2, 32'd3, 32'd5, 4'b0000, 1);
        @(posedge clk); #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
